// File: rtl/video_proc_pkg.sv
// Shared instruction layout, opcode constants and dispatcher FSM encoding.
package video_proc_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPC_W    = 4;
  localparam int DATA_W   = 28;
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int DATA_MSB = 27;
  localparam int DATA_LSB = 0;

  typedef logic [OPC_W-1:0]  opcode_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam opcode_t OP_CLEAR  = 4'b0000;
  localparam opcode_t OP_DRAW   = 4'b0001;
  localparam opcode_t OP_TEXT   = 4'b0010;
  localparam opcode_t OP_STATUS = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  function automatic opcode_t instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic data_t instr_data(input logic [INSTR_W-1:0] instr);
    return instr[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/instr_dispatcher_if.sv
// Host-write and control-unit signal bundle of the instruction dispatcher.
interface instr_dispatcher_if #(
  parameter int DEPTH = 8
);
  import video_proc_pkg::*;

  // Handshake: the host write is taken on every cycle with wr_en=1 unless the FIFO is
  // full with no pop in that cycle (then drop pulses). An instruction is handed over on
  // the one-cycle issue pulse; the control unit accepts it by raising ctrl_busy and
  // signals completion by lowering ctrl_busy again.
  logic                   wr_en;
  logic [INSTR_W-1:0]     wr_data;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   drop;
  logic                   ctrl_busy;
  logic                   printing;
  opcode_t                opcode;
  data_t                  data;
  logic                   issue;
  logic                   illegal;
  logic                   error;
  logic                   err_clr;
  state_t                 fsm_state;

  modport master (
    output wr_en, wr_data, ctrl_busy, printing, err_clr,
    input  full, count, drop, opcode, data, issue, illegal, error, fsm_state
  );

  modport slave (
    input  wr_en, wr_data, ctrl_busy, printing, err_clr,
    output full, count, drop, opcode, data, issue, illegal, error, fsm_state
  );

endinterface

// File: rtl/instr_fifo.sv
// Instruction FIFO with show-ahead head, occupancy count and a registered drop pulse.
module instr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_req,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full,
  output logic                   drop,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             push;
  logic             pop_ok;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop_ok = pop && !empty;
  assign push   = push_req && (!full || pop_ok);
  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign head   = mem[rd_ptr];
  assign count  = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop    <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop_ok)      count_q <= count_q + 1'b1;
      else if (!push && pop_ok) count_q <= count_q - 1'b1;
      drop <= push_req && !push;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_dispatcher.sv
// Buffers host instructions and hands them to the control unit one at a time.
// Optional watchdog on WAIT_DONE is compiled in with DISPATCH_WATCHDOG_EN.
module instr_dispatcher
  import video_proc_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ACK_WAIT = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  instr_dispatcher_if.slave  bus
);

  localparam int CNT_MAX = (TIMEOUT > ACK_WAIT) ? TIMEOUT : ACK_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [INSTR_W-1:0] head;
  logic               empty;
  logic               pop;
  opcode_t            head_op;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_req (bus.wr_en),
    .wdata    (bus.wr_data),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .full     (bus.full),
    .drop     (bus.drop),
    .count    (bus.count)
  );

  assign head_op = instr_opcode(head);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  opcode_t          opcode_q;
  data_t            data_q;
  logic             issue_q, illegal_q;
  logic             load, illegal_d;
`ifdef DISPATCH_WATCHDOG_EN
  logic             wd_fire;
  logic             error_q;
`endif

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load      = 1'b0;
    illegal_d = 1'b0;
`ifdef DISPATCH_WATCHDOG_EN
    wd_fire   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (head_op > OP_STATUS) begin
            pop       = 1'b1;
            illegal_d = 1'b1;
          end else if (!bus.ctrl_busy && (head_op == OP_STATUS || !bus.printing)) begin
            // Status opcodes bypass the print interlock; the others wait for it.
            pop     = 1'b1;
            load    = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = (opcode_q == OP_STATUS) ? ST_IDLE : ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (bus.ctrl_busy)                         state_d = ST_WAIT_DONE;
        else if (cnt_q == CNT_W'(ACK_WAIT - 1))    state_d = ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (!bus.ctrl_busy) state_d = ST_IDLE;
`ifdef DISPATCH_WATCHDOG_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          wd_fire = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cnt_q counts cycles spent in the current wait state, starting at 0 on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      opcode_q  <= OP_STATUS;
      data_q    <= '0;
      issue_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (state_d != state_q || state_q == ST_IDLE || state_q == ST_ISSUE) cnt_q <= '0;
      else                                                                 cnt_q <= cnt_q + 1'b1;
      issue_q   <= load;
      illegal_q <= illegal_d;
      if (load) begin
        opcode_q <= head_op;
        data_q   <= instr_data(head);
      end
    end
  end

`ifdef DISPATCH_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           error_q <= 1'b0;
    else if (wd_fire)     error_q <= 1'b1;
    else if (bus.err_clr) error_q <= 1'b0;
  end
  assign bus.error = error_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.error      = 1'b0;
`endif

  assign bus.opcode    = opcode_q;
  assign bus.data      = data_q;
  assign bus.issue     = issue_q;
  assign bus.illegal   = illegal_q;
  assign bus.fsm_state = state_q;

endmodule

// File: doc/instr_dispatcher.md
INSTR_DISPATCHER -- requirements
Module: instr_dispatcher

Interface
REQ-001 Parameter DEPTH, 8, instruction FIFO depth; power of two, 2..64.
REQ-002 Parameter ACK_WAIT, 4, cycles allowed for ctrl_busy to rise after issue.
REQ-003 Parameter TIMEOUT, 1024, watchdog limit in cycles for WAIT_DONE.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 wr_en  in  1  host write strobe; one instruction per high cycle.
REQ-007 wr_data  in  32  instruction: opcode [31:28], data [27:0].
REQ-008 full  out  1  FIFO full.
REQ-009 count  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-010 drop  out  1  one-cycle pulse when a write is rejected.
REQ-011 ctrl_busy  in  1  control unit not ready; 0 = may accept an instruction.
REQ-012 printing  in  1  screen print in progress; 1 = printing.
REQ-013 opcode  out  4  opcode presented to the control unit.
REQ-014 data  out  28  data field presented to the decoder and register bank.
REQ-015 issue  out  1  one-cycle pulse marking a new opcode/data pair.
REQ-016 illegal  out  1  one-cycle pulse when an opcode above 4'b0011 is discarded.
REQ-017 error  out  1  sticky watchdog error flag.
REQ-018 err_clr  in  1  synchronous clear of error.

Function
REQ-019 The FIFO SHALL push on wr_en when not full, or when full with a pop in the same cycle; otherwise it SHALL reject the write and pulse drop.
REQ-020 The FSM SHALL have four states: IDLE, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-021 IDLE: with the FIFO non-empty and the head opcode above 4'b0011, the block SHALL pop the entry, pulse illegal and stay in IDLE.
REQ-022 IDLE: with head opcode 4'b0000-4'b0010, printing=0 and ctrl_busy=0, the block SHALL pop the entry and go to ISSUE; while printing=1 the entry SHALL be held and not popped.
REQ-023 IDLE: with head opcode 4'b0011 and ctrl_busy=0, the block SHALL pop the entry and go to ISSUE regardless of printing.
REQ-024 ISSUE: the block SHALL register opcode/data and pulse issue for exactly one cycle, then go to WAIT_ACK for opcodes 0000-0010 or to IDLE for opcode 0011.
REQ-025 WAIT_ACK: ctrl_busy=1 SHALL move the FSM to WAIT_DONE; if no ctrl_busy=1 is seen within ACK_WAIT cycles, the FSM SHALL return to IDLE.
REQ-026 WAIT_DONE: ctrl_busy=0 SHALL move the FSM to IDLE.
REQ-027 opcode and data SHALL hold their values from ISSUE until the next ISSUE.
REQ-028 The minimum latency from a wr_en edge into an empty FIFO to the issue pulse SHALL be 2 clk edges.
REQ-029 Sustained throughput SHALL be at most one instruction per 2 cycles.
REQ-030 The FIFO pointers SHALL wrap modulo DEPTH.
REQ-031 count SHALL saturate neither high nor low; push and pop in the same cycle SHALL leave count unchanged.

Reset
REQ-032 When reset is low, the block SHALL set the FSM to IDLE and the FIFO to empty.
REQ-033 While reset is low, full, drop, issue and illegal SHALL be 0.
REQ-034 While reset is low, opcode SHALL be 4'b0011, data SHALL be 0, error SHALL be 0 and count SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL discard all buffered instructions and clear the in-flight transaction without issuing further pulses.

Configuration
REQ-036 The macro DISPATCH_WATCHDOG_EN SHALL compile the watchdog in or out.
REQ-037 With DISPATCH_WATCHDOG_EN defined, a cycle counter SHALL run in WAIT_DONE; on reaching TIMEOUT the block SHALL set error and return to IDLE.
REQ-038 With DISPATCH_WATCHDOG_EN defined, error SHALL clear on err_clr=1 and a simultaneous set SHALL win.
REQ-039 Without DISPATCH_WATCHDOG_EN, WAIT_DONE SHALL wait indefinitely, error SHALL be tied to 0 and err_clr SHALL be ignored.

Structure
REQ-040 The shared package video_proc_pkg SHALL hold the opcode constants (0000-0011), the instruction field widths and positions, and the FSM state encoding.
REQ-041 The FIFO SHALL be a separate sub-module, instr_fifo, parameterised by DEPTH and WIDTH=32.

Verification
REQ-042 The bench SHALL cover: write 0x1000_00AB into an empty FIFO with ctrl_busy=0 and printing=0 -> issue pulses 2 edges later with opcode=1, data=0x00000AB, then the FSM enters WAIT_ACK.
REQ-043 The bench SHALL cover: with printing=1, queue opcodes 0, then 3 -> nothing issues and count=2; after printing drops, opcode 0 issues first.
REQ-044 The bench SHALL cover: 9 back-to-back writes with DEPTH=8 and ctrl_busy=1 -> full=1 after the 8th and drop pulses once on the 9th.
REQ-045 The bench SHALL cover: write opcode 4'b0111 -> illegal pulses, count returns to 0 and issue stays 0.
REQ-046 The bench SHALL cover: with the macro on, TIMEOUT=16 and ctrl_busy held 1 after an opcode 2 issue -> error=1 at cycle 16 of WAIT_DONE; err_clr then gives error=0.
REQ-047 The bench SHALL cover: assert reset during WAIT_DONE with 3 entries queued -> count=0, FSM in IDLE, and no issue after release.
